// File: rtl/spi_reg_pkg.sv
// Shared frame constants, register map and FSM encoding for the SPI register-frame initiator.
package spi_reg_pkg;
  localparam int FRAME_BITS = 40;
  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 24;
  localparam logic FLAG_READ = 1'b1;

  localparam logic [ADDR_BITS-1:0] REG_LED     = 7'd7;
  localparam logic [ADDR_BITS-1:0] REG_SPI_MUX = 7'd8;
  localparam logic [ADDR_BITS-1:0] REG_4094    = 7'd9;

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_e;

  // {flag, addr, 8'h00, data}; read frames carry zero data.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic                 wr,
                                                        input logic [ADDR_BITS-1:0] addr,
                                                        input logic [DATA_BITS-1:0] data);
    return {(wr ? ~FLAG_READ : FLAG_READ), addr, 8'h00, (wr ? data : {DATA_BITS{1'b0}})};
  endfunction
endpackage

// File: rtl/spi_tick_gen.sv
// Half-period strobe: pulses once every CLK_DIV clocks while enabled, restarts from zero when disabled.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_reg_master.sv
// SPI initiator for 40-bit register frames: accepts one command, shifts it out MSB first,
// captures the 24-bit read value and pulses rsp_valid_o at CS release.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [ADDR_BITS-1:0] cmd_addr_i,
  input  logic [DATA_BITS-1:0] cmd_wdata_i,
  output logic                 rsp_valid_o,
  output logic [DATA_BITS-1:0] rsp_rdata_o,
  output logic                 busy_o,
  output logic                 spi_cs_o,
  output logic                 spi_clk_o,
  output logic                 spi_mosi_o,
  input  logic                 spi_miso_i
);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);
  localparam logic [7:0] SHIFT_LAST = 8'(2 * FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic [DATA_BITS-1:0]    rx_q, rx_d, rdata_q, rdata_d;
  logic                    rd_q, rd_d, ready_q, ready_d, busy_q, busy_d;
  logic                    cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d, rsp_q, rsp_d;
  logic                    tick, do_rise;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    rdata_d = rdata_q;
    rsp_d   = 1'b0;
    do_rise = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_valid_i && ready_q) begin
        sr_d    = build_frame(cmd_write_i, cmd_addr_i, cmd_wdata_i);
        rd_d    = !cmd_write_i;
        cs_d    = 1'b0;
        busy_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_SETUP;
      end
      // The last setup tick is also the first SCLK rise, so CS-to-rise is exactly CS_SETUP ticks.
      ST_SETUP: if (tick) begin
        if (cnt_q == SETUP_LAST) begin
          do_rise = 1'b1;
          cnt_d   = 8'd1;
          state_d = ST_SHIFT;
        end else cnt_d = cnt_q + 8'd1;
      end
      ST_SHIFT: if (tick) begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q[0]) begin
          sclk_d = 1'b0;
          if (cnt_q == SHIFT_LAST) begin
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end else do_rise = 1'b1;
      end
      ST_HOLD: if (tick) begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          rsp_d   = 1'b1;
          if (rd_q) rdata_d = rx_q;
          state_d = ST_GAP;
        end else cnt_d = cnt_q + 8'd1;
      end
      ST_GAP: if (tick) begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // MISO is sampled on the same clock that raises SCLK; the responder shifted it on the prior fall.
    if (do_rise) begin
      sclk_d = 1'b1;
      mosi_d = sr_q[FRAME_BITS-1];
      sr_d   = {sr_q[FRAME_BITS-2:0], 1'b0};
      rx_d   = {rx_q[DATA_BITS-2:0], spi_miso_i};
    end
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      rx_q    <= '0;
      rd_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      rsp_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_q;
  assign rsp_rdata_o = rdata_q;
  assign busy_o      = busy_q;
  assign spi_cs_o    = cs_q;
  assign spi_clk_o   = sclk_q;
  assign spi_mosi_o  = mosi_q;
endmodule

// File: doc/spi_reg_master.md
Name: spi_reg_master

Overview:
- FPGA-side SPI initiator that issues 40-bit register frames to the DMM register-bank SPI responder. Each frame is either a write or a read.
- Accepts a valid/ready command from internal logic and generates the CS, SCLK and MOSI waveforms.
- For reads, captures MISO and returns the 24-bit register value with a one-cycle response pulse.
- Used for board bring-up, loopback self-test, and driving a second FPGA's register bank.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period; legal range ≥1.
- CS_SETUP, 2, SCLK half-periods from CS falling to the first SCLK rise; ≥1.
- CS_HOLD, 2, SCLK half-periods from the last SCLK fall to CS rising; ≥1.
- CS_GAP, 4, minimum SCLK half-periods CS stays high between frames; ≥1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- cmd_valid, input, 1, command request.
- cmd_ready, output, 1, high when a command is accepted on this cycle if cmd_valid is also high.
- cmd_write, input, 1, 1 = write, 0 = read.
- cmd_addr, input, 7, register address.
- cmd_wdata, input, 24, write data; ignored for reads.
- rsp_valid, output, 1, one-cycle pulse at frame completion, for both reads and writes.
- rsp_rdata, output, 24, read data; held until the next completion.
- busy, output, 1, high from command acceptance until the gap expires.
- spi_cs, output, 1, chip select, active low.
- spi_clk, output, 1, SCLK; idles low.
- spi_mosi, output, 1, serial data to the responder.
- spi_miso, input, 1, serial data from the responder.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: spi_cs=1, spi_clk=0, spi_mosi=0, cmd_ready=0 during reset and 1 in the first IDLE cycle after reset, rsp_valid=0, rsp_rdata=0, busy=0.
- Frame format, 40 bits, MSB first:
  - bit39 = flag (0 = write, 1 = read).
  - bits38..32 = addr.
  - bits31..24 = 0.
  - bits23..0 = wdata for writes, 0 for reads.
- Read return: the value is the last 24 MISO bits sampled, i.e. frame bits 23..0.
- SCLK/data phasing (responder samples and shifts on SCLK fall):
  - The master updates MOSI on each SCLK rise.
  - The master samples MISO on the same system-clock cycle it raises SCLK.
- Half-period tick: pulses every CLK_DIV clks while not in IDLE.
- State machine:
  - IDLE: cmd_ready=1. Handshake is cmd_valid&cmd_ready. On handshake, latch the command into a 40-bit shift register, drive cs=0, busy=1, go to SETUP. cmd_ready drops the cycle after acceptance.
  - SETUP: wait CS_SETUP ticks with SCLK low, then go to SHIFT.
  - SHIFT: 80 ticks, alternating SCLK rise and fall, starting with a rise.
    - On rise k (k=1..40): mosi = sr[39], shift sr left, shift miso into rx.
    - After fall 40, go to HOLD.
    - Exactly 40 SCLK rises per frame; the responder only commits a write when it sees exactly 40.
  - HOLD: CS_HOLD ticks, then cs=1. On the same cycle: rsp_valid=1 for one clk, and rsp_rdata=rx[23:0] if the frame was a read (unchanged for writes). Go to GAP.
  - GAP: CS_GAP ticks with cs=1, then busy=0, return to IDLE.
- cmd_valid while not in IDLE: not accepted, and no effect.
- Reset mid-frame: outputs go to their reset values immediately, asynchronously. The partial frame has fewer than 40 SCLKs, so the responder discards it.
- Command lifecycle: commands are never dropped once accepted; one command produces exactly one rsp_valid.
- SCLK period = 2*CLK_DIV clks.
- Worst-case frame occupancy = (CS_SETUP+80+CS_HOLD+CS_GAP)*CLK_DIV clks, plus 1 clk for acceptance.

Decomposition:
- spi_reg_pkg holds:
  - frame constants: FRAME_BITS=40, ADDR_BITS=7, DATA_BITS=24, FLAG_READ=1;
  - register addresses: REG_LED=7, REG_SPI_MUX=8, REG_4094=9.
- One sub-module, spi_tick_gen: a CLK_DIV half-period tick counter with enable and async clear.

Test Plan:
- Write REG_LED=0x000015 with CLK_DIV=4 → MOSI stream 0x0700000015, exactly 40 SCLK rises, SCLK period 8 clks, one rsp_valid; the behavioural responder model shows reg_led=0x15.
- Read REG_SPI_MUX with the model holding 0xABCDEF → MOSI first byte 0x88; rsp_rdata=0xABCDEF on the rsp_valid cycle and held afterwards.
- cmd_valid held high for 3 commands → cmd_ready low while busy; CS high for ≥CS_GAP*CLK_DIV clks between frames; 3 rsp_valid pulses, in order.
- rst_n asserted after SCLK rise 20 → spi_cs=1, spi_clk=0 immediately; model register unchanged; after release, a new write completes normally.
- CLK_DIV=1 → read of REG_4094=0x123456 returns the correct value; SCLK toggles every clk.
- Write to unmapped address 0x7F followed by a read → model default returned (12345 truncated to 24 bits = 0x003039); no mapped register changed.
